// File: rtl/led_seq_ctrl.sv
// Command-driven 4-LED flow/blink sequencer with a programmable step prescaler.
// Commands arrive over a valid/ready port and take priority over a coincident prescaler step.
module led_seq_ctrl #(
  parameter int STEP_DIV = 10_000_000,
  parameter int CNT_W    = 24
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_arg,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       paused,
  output logic       step_pulse
);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_PAUSED} state_e;

  localparam logic [2:0] OP_SET_MODE  = 3'd1;
  localparam logic [2:0] OP_SET_SPEED = 3'd2;
  localparam logic [2:0] OP_PAUSE     = 3'd3;
  localparam logic [2:0] OP_RESUME    = 3'd4;
  localparam logic [2:0] OP_STEP      = 3'd5;

  localparam logic [1:0] M_OFF    = 2'd0;
  localparam logic [1:0] M_FLOW_L = 2'd1;
  localparam logic [1:0] M_FLOW_R = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  state_e           state, state_nxt;
  logic [1:0]       speed;
  logic [CNT_W-1:0] cnt, div;
  logic             accept, wrap, cnt_clr;

  function automatic logic [3:0] step_led(input logic [3:0] cur, input logic [1:0] m);
    case (m)
      M_FLOW_L: return {cur[2:0], cur[3]};
      M_FLOW_R: return {cur[0], cur[3:1]};
      M_BLINK:  return ~cur;
      default:  return cur;
    endcase
  endfunction

  function automatic logic [3:0] seed_led(input logic [1:0] m);
    case (m)
      M_FLOW_L: return 4'b0001;
      M_FLOW_R: return 4'b1000;
      M_BLINK:  return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  assign accept = cmd_valid & cmd_ready;
  assign div    = CNT_W'(STEP_DIV >> speed);
  assign wrap   = (state == ST_RUN) && (cnt == div - CNT_W'(1));

  // State register
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (sys_rst) state <= ST_OFF;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (accept) begin
      case (cmd_op)
        OP_SET_MODE: begin
          if (cmd_arg == M_OFF)       state_nxt = ST_OFF;
          else if (state != ST_PAUSED) state_nxt = ST_RUN;
        end
        OP_PAUSE:  if (state == ST_RUN)    state_nxt = ST_PAUSED;
        OP_RESUME: if (state == ST_PAUSED) state_nxt = ST_RUN;
        default: ;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    paused = (state == ST_PAUSED);
  end

  // Counter restarts on a wrap, whenever we will not be running, or on timing-relevant commands.
  always_comb begin
    cnt_clr = wrap || (state_nxt != ST_RUN) ||
              (accept && (cmd_op == OP_SET_MODE || cmd_op == OP_SET_SPEED ||
                          cmd_op == OP_RESUME));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led        <= 4'b0000;
      mode       <= M_OFF;
      speed      <= 2'd0;
      cnt        <= '0;
      step_pulse <= 1'b0;
      cmd_ready  <= 1'b0;
    end else begin
      cmd_ready  <= ~accept;
      step_pulse <= 1'b0;
      cnt        <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (accept) begin
        // An accepted command swallows any prescaler step due at this edge.
        case (cmd_op)
          OP_SET_MODE: begin
            mode <= cmd_arg;
            led  <= seed_led(cmd_arg);
          end
          OP_SET_SPEED: speed <= cmd_arg;
          OP_STEP: begin
            if (state == ST_PAUSED && mode != M_OFF) begin
              led        <= step_led(led, mode);
              step_pulse <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (wrap) begin
        led        <= step_led(led, mode);
        step_pulse <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with STEP_DIV=8: flow/blink stepping, pause/step/resume,
// command handshake spacing, command-vs-wrap priority and synchronous reset.
module tb_led_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_arg = 2'd0;
  logic [3:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       step_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  led_seq_ctrl #(.STEP_DIV(8), .CNT_W(4)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .led        (led),
    .mode       (mode),
    .paused     (paused),
    .step_pulse (step_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Waits (bounded) for cmd_ready, then presents the command for exactly one accept edge.
  task automatic send(input string tag, input logic [2:0] op, input logic [1:0] arg);
    int k = 0;
    while (!cmd_ready && k < 20) begin
      tick(1);
      k++;
    end
    check({tag, "_ready"}, {7'd0, cmd_ready}, 8'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick(1);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = 2'd0;
  endtask

  initial begin
    int pc;

    // Reset state
    tick(2);
    check("rst_led",   {4'd0, led}, 8'h0);
    check("rst_mode",  {6'd0, mode}, 8'h0);
    check("rst_pause", {7'd0, paused}, 8'h0);
    check("rst_pulse", {7'd0, step_pulse}, 8'h0);
    check("rst_ready", {7'd0, cmd_ready}, 8'h0);
    sys_rst = 1'b0;
    tick(1);
    check("post_rst_ready", {7'd0, cmd_ready}, 8'h1);

    // FLOW_L at speed 0: one rotation every 8 cycles
    send("flowl", 3'd1, 2'd1);
    check("flowl_seed",  {4'd0, led}, 8'h1);
    check("flowl_mode",  {6'd0, mode}, 8'h1);
    check("flowl_rdy0",  {7'd0, cmd_ready}, 8'h0);
    tick(7);
    check("flowl_c7_led",   {4'd0, led}, 8'h1);
    check("flowl_c7_pulse", {7'd0, step_pulse}, 8'h0);
    tick(1);
    check("flowl_c8_led",   {4'd0, led}, 8'h2);
    check("flowl_c8_pulse", {7'd0, step_pulse}, 8'h1);
    tick(1);
    check("flowl_c9_pulse", {7'd0, step_pulse}, 8'h0);
    tick(7);
    check("flowl_c16_led",   {4'd0, led}, 8'h4);
    check("flowl_c16_pulse", {7'd0, step_pulse}, 8'h1);
    tick(8);
    check("flowl_c24_led", {4'd0, led}, 8'h8);
    tick(8);
    check("flowl_c32_led",   {4'd0, led}, 8'h1);
    check("flowl_c32_pulse", {7'd0, step_pulse}, 8'h1);

    // FLOW_R, then speed 2 (div = 2)
    send("flowr", 3'd1, 2'd2);
    check("flowr_seed", {4'd0, led}, 8'h8);
    check("flowr_mode", {6'd0, mode}, 8'h2);
    send("spd2", 3'd2, 2'd2);
    check("spd2_led", {4'd0, led}, 8'h8);
    tick(1);
    check("spd2_c1_led", {4'd0, led}, 8'h8);
    tick(1);
    check("spd2_c2_led",   {4'd0, led}, 8'h4);
    check("spd2_c2_pulse", {7'd0, step_pulse}, 8'h1);
    tick(2);
    check("spd2_c4_led", {4'd0, led}, 8'h2);

    // BLINK at speed 0, pause mid-period, single steps, resume
    send("spd0", 3'd2, 2'd0);
    send("blink", 3'd1, 2'd3);
    check("blink_seed", {4'd0, led}, 8'hF);
    check("blink_mode", {6'd0, mode}, 8'h3);
    tick(3);
    send("pause", 3'd3, 2'd0);
    check("pause_flag", {7'd0, paused}, 8'h1);
    check("pause_led",  {4'd0, led}, 8'hF);
    pc = 0;
    repeat (50) begin
      tick(1);
      if (step_pulse) pc++;
    end
    check("pause_no_pulse", 8'(pc), 8'd0);
    check("pause_frozen",   {4'd0, led}, 8'hF);
    send("step1", 3'd5, 2'd0);
    check("step1_led",   {4'd0, led}, 8'h0);
    check("step1_pulse", {7'd0, step_pulse}, 8'h1);
    tick(1);
    check("step1_pulse_end", {7'd0, step_pulse}, 8'h0);
    send("step2", 3'd5, 2'd0);
    check("step2_led",   {4'd0, led}, 8'hF);
    check("step2_pulse", {7'd0, step_pulse}, 8'h1);
    check("step2_paused", {7'd0, paused}, 8'h1);
    send("resume", 3'd4, 2'd0);
    check("resume_paused", {7'd0, paused}, 8'h0);
    tick(7);
    check("resume_c7_led", {4'd0, led}, 8'hF);
    tick(1);
    check("resume_c8_led",   {4'd0, led}, 8'h0);
    check("resume_c8_pulse", {7'd0, step_pulse}, 8'h1);

    // Back-to-back: cmd_valid held high across two commands
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_arg   = 2'd1;
    tick(1);
    check("b2b_first_mode", {6'd0, mode}, 8'h1);
    check("b2b_first_rdy",  {7'd0, cmd_ready}, 8'h0);
    cmd_arg = 2'd2;
    tick(1);
    check("b2b_gap_mode", {6'd0, mode}, 8'h1);
    check("b2b_gap_rdy",  {7'd0, cmd_ready}, 8'h1);
    tick(1);
    check("b2b_second_mode", {6'd0, mode}, 8'h2);
    check("b2b_second_led",  {4'd0, led}, 8'h8);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = 2'd0;

    // SET_MODE FLOW_L landing on the wrap edge: seed only, no pulse
    tick(7);
    check("wrap_pre_led", {4'd0, led}, 8'h8);
    send("wrapcmd", 3'd1, 2'd1);
    check("wrapcmd_led",   {4'd0, led}, 8'h1);
    check("wrapcmd_pulse", {7'd0, step_pulse}, 8'h0);
    tick(7);
    check("wrapcmd_c7_led", {4'd0, led}, 8'h1);
    tick(1);
    check("wrapcmd_c8_led", {4'd0, led}, 8'h2);

    // Reserved opcode and STEP while running: no effect, prescaler keeps counting
    send("op7", 3'd7, 2'd3);
    check("op7_led",  {4'd0, led}, 8'h2);
    check("op7_mode", {6'd0, mode}, 8'h1);
    send("run_step", 3'd5, 2'd0);
    check("run_step_led",   {4'd0, led}, 8'h2);
    check("run_step_pulse", {7'd0, step_pulse}, 8'h0);
    check("run_step_pause", {7'd0, paused}, 8'h0);
    tick(4);
    check("run_c7_led", {4'd0, led}, 8'h2);
    tick(1);
    check("run_c8_led", {4'd0, led}, 8'h4);

    // Reset in RUN with a command held on the port
    sys_rst   = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_arg   = 2'd2;
    tick(1);
    check("rst2_led",   {4'd0, led}, 8'h0);
    check("rst2_mode",  {6'd0, mode}, 8'h0);
    check("rst2_ready", {7'd0, cmd_ready}, 8'h0);
    check("rst2_pulse", {7'd0, step_pulse}, 8'h0);
    tick(1);
    check("rst2_hold_mode", {6'd0, mode}, 8'h0);
    sys_rst = 1'b0;
    tick(1);
    check("rst2_rel_mode",  {6'd0, mode}, 8'h0);
    check("rst2_rel_led",   {4'd0, led}, 8'h0);
    check("rst2_rel_ready", {7'd0, cmd_ready}, 8'h1);
    cmd_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Command-driven sequencer for the 4-LED flow display.
- Owns the step-rate prescaler, the pattern mode and the run/pause state.
- Applies flow-left, flow-right or blink patterns to the LED register at a programmable step rate.
- A host-side block (key decoder or UART command parser) drives it through a valid/ready command port.

Parameters:
- STEP_DIV, 10_000_000, base clock cycles per LED step at speed 0 (0.2 s at 50 MHz); must be >= 8; simulation uses 8.
- CNT_W, 24, prescaler counter width; must satisfy 2^CNT_W > STEP_DIV.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  3  opcode: 0 NOP, 1 SET_MODE, 2 SET_SPEED, 3 PAUSE, 4 RESUME, 5 STEP; 6-7 reserved.
- cmd_arg  in  2  operand. SET_MODE: 0 OFF, 1 FLOW_L, 2 FLOW_R, 3 BLINK. SET_SPEED: shift 0-3.
- led  out  4  LED drive, registered.
- mode  out  2  current mode code, registered.
- paused  out  1  high in PAUSED state.
- step_pulse  out  1  one-cycle pulse on each applied step.

Behaviour:
- Reset, on a sys_clk edge with sys_rst=1:
  - led=0000, mode=OFF, speed=0, state=OFF, cnt=0.
  - step_pulse=0, paused=0, cmd_ready=0.
  - sys_rst has priority over every other input.
- cmd_ready is registered:
  - 0 during reset.
  - 0 in the cycle after an accept.
  - 1 otherwise.
  - At most one command accepted per 2 cycles.
- Accept = cmd_valid & cmd_ready at a clock edge. Its effect is visible in registers right after that edge.
- Reserved and NOP opcodes are accepted with no effect.
- Control FSM states: OFF, RUN, PAUSED.
  - SET_MODE OFF from any state -> OFF, led=0000.
  - SET_MODE m≠OFF:
    - From OFF or RUN -> RUN.
    - From PAUSED -> stays PAUSED.
    - led loads the seed: FLOW_L 0001, FLOW_R 1000, BLINK 1111.
    - cnt cleared.
  - PAUSE: RUN -> PAUSED. Ignored in OFF/PAUSED.
  - RESUME: PAUSED -> RUN with cnt cleared. Ignored elsewhere.
  - STEP: only in PAUSED. Applies exactly one pattern step and pulses step_pulse at the same edge. Ignored elsewhere.
  - SET_SPEED: speed=cmd_arg and cnt cleared in any state. State unchanged.
- Prescaler:
  - div = STEP_DIV >> speed.
  - In RUN, cnt increments 0..div-1; at cnt==div-1 it wraps to 0 and a step is applied.
  - Step period is exactly div cycles.
  - In OFF and PAUSED, cnt holds 0.
- Pattern step:
  - FLOW_L: led <= {led[2:0], led[3]}.
  - FLOW_R: led <= {led[0], led[3:1]}.
  - BLINK: led <= ~led.
  - OFF: no step.
- step_pulse is high for exactly the cycle after the edge at which a step was applied.
- Simultaneous events: a command accepted at the same edge as a prescaler wrap takes priority. The step is dropped (no led change, no step_pulse) and cnt is cleared or wrapped to 0.
- The pattern never goes all-zero in flow modes. Rotation wraps bit 3 <-> bit 0.

Test Plan (STEP_DIV=8):
- Reset, then SET_MODE FLOW_L, speed 0 -> led=0001 after the accept edge. After 8, 16, 24, 32 cycles: 0010, 0100, 1000, 0001. step_pulse appears every 8 cycles.
- SET_MODE FLOW_R, then SET_SPEED 2 -> led=1000, then 0100, 0010 at 2-cycle intervals.
- BLINK, PAUSE mid-period -> led frozen, paused=1, no step_pulse for 50 cycles. Two STEP commands -> led 1111->0000->1111, one step_pulse each. RESUME -> next step exactly 8 cycles later.
- Two back-to-back commands with cmd_valid held high -> the second is accepted 2 cycles after the first (cmd_ready low one cycle). SET_MODE issued at the wrap cycle -> led takes the seed, with no extra rotation and no step_pulse.
- Assert sys_rst in RUN, FLOW_L, led=0100 -> at the next edge led=0000, mode=OFF, cmd_ready=0. Commands with cmd_valid high during reset are not accepted. Opcode 7 and STEP in RUN -> no state change.
